cpu_run_ctrl: RTL
=================

Name:
cpu_run_ctrl

Overview:
Run/halt sequencer for the single-cycle CPU. It starts execution, gates the CPU write enable, and detects the halt word or a cycle-budget timeout. After the CPU stops, it dumps the architectural state in a fixed order over a valid/ready stream: PC, then data memory, then register file. It sits beside the Simple_Single_CPU top, and its debug read addresses drive the asynchronous read ports of the data memory and register file.

Parameters:
MEM_WORDS, 32, data-memory words dumped (index 1..MEM_WORDS)
REG_NUM, 32, registers dumped (index MEM_WORDS+1..MEM_WORDS+REG_NUM)
MAX_CYCLES, 200, run-cycle budget before forced stop
HALT_WORD, 32'hFFFFFFFF, instruction encoding that stops execution

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  synchronous, active-high reset
start_i  in  1  begin execution; sampled only in IDLE
instr_i  in  32  current instruction from instruction memory
pc_i  in  32  current PC value
run_o  out  1  CPU enable; gates PC update, register write and memory write
halted_o  out  1  stop caused by HALT_WORD
timeout_o  out  1  stop caused by budget exhaustion
cycle_cnt_o  out  16  executed cycles
dbg_mem_addr_o  out  5  data-memory debug read word address
dbg_reg_addr_o  out  5  register-file debug read address
mem_rdata_i  in  32  data-memory debug read data (combinational)
reg_rdata_i  in  32  register-file debug read data (combinational)
dump_valid_o  out  1  dump word valid
dump_ready_i  in  1  consumer accepts word
dump_data_o  out  32  dump word
dump_idx_o  out  7  0 = PC, 1..32 = mem[idx-1], 33..64 = reg[idx-33]
dump_last_o  out  1  high with final word (idx 64)
done_o  out  1  dump complete

Behaviour:
- States: IDLE, RUN, DUMP, DONE. On reset: state IDLE; every output 0; cycle_cnt 0; idx 0; pc_latch 0.
- IDLE: if start_i, go to RUN next edge and clear cycle_cnt.
- RUN, combinational enable: run_o = (state==RUN) && (instr_i != HALT_WORD) && !budget_hit. Here budget_hit = (cycle_cnt == MAX_CYCLES-1).
  - The halt instruction therefore never commits, and the PC holds at the halt address.
- RUN, each edge:
  - if instr_i==HALT_WORD: latch pc_i, set halted_o, go to DUMP with idx 0.
  - else if budget_hit: latch pc_i, set timeout_o, go to DUMP.
  - else: cycle_cnt += 1.
  - If both conditions hold on the same edge, halt wins: halted_o=1, timeout_o=0.
- start_i is ignored outside IDLE.
- DUMP:
  - dump_valid_o=1.
  - dump_data_o: pc_latch when idx==0; mem_rdata_i when idx is 1..MEM_WORDS; reg_rdata_i otherwise.
  - dbg_mem_addr_o = idx-1 (low 5 bits); dbg_reg_addr_o = idx-33 (low 5 bits); both are don't-care outside their ranges.
  - On each edge with dump_ready_i high, idx increments.
  - While dump_ready_i is low, data and idx hold stable.
  - dump_last_o = (idx == MEM_WORDS+REG_NUM).
  - The handshake on the last word moves to DONE.
- DONE: done_o=1 and dump_valid_o=0; halted_o/timeout_o/cycle_cnt_o hold. Only rst_i leaves DONE.
- rst_i has priority in every state, including mid-dump: next edge is IDLE with all outputs cleared, and a partial dump is abandoned.
- cycle_cnt_o width of 16 must exceed MAX_CYCLES; there is no wrap within the budget.

Decomposition:
- Shared package: state encoding (IDLE/RUN/DUMP/DONE), HALT_WORD, dump index bases PC_IDX=0, MEM_IDX_BASE=1, REG_IDX_BASE=MEM_WORDS+1.
- One natural sub-module, dump_seq: index counter, address split and output mux, handshake. The top keeps the FSM and cycle budget.

Test Plan:
- Program with halt at PC 0x0C, dump_ready_i tied high → run_o low in the halt cycle; halted_o=1, cycle_cnt_o=3. Exactly 65 handshakes follow: idx0 data 0x0000000C, then mem, then regs; dump_last_o only at idx 64; done_o on the next edge.
- Same program, dump_ready_i toggling 1-0-0-1 → each word held stable while ready is low. Order and count unchanged, no duplicates.
- Infinite loop (beq to self), MAX_CYCLES=200 → run_o low in cycle 199 and timeout_o=1. Dump idx0 equals the loop PC; halted_o=0.
- HALT_WORD as the first instruction → run_o never high; cycle_cnt_o=0; dump idx0=0x00000000.
- rst_i asserted at idx 20 of the dump → next edge: IDLE, dump_valid_o=0, done_o=0, halted_o=0. A new start_i then runs to a full 65-word dump.
- start_i pulsed during RUN and again in DONE → no effect: cycle_cnt continues counting in RUN, and done_o holds in DONE.

Source files
------------

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared encodings for the CPU run/halt sequencer: FSM states, halt word and dump index map.
package cpu_run_ctrl_pkg;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDump = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic [31:0] HaltWordDefault = 32'hFFFF_FFFF;

  localparam int unsigned PcIdx      = 0;
  localparam int unsigned MemIdxBase = 1;

  typedef logic [6:0] dump_idx_t;

  // Register file words follow the PC word and the data-memory words.
  function automatic int unsigned reg_idx_base(input int unsigned mem_words);
    return mem_words + 1;
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_dump_seq.sv
// Architectural-state dump sequencer: index counter, debug address split, data mux, handshake.
module cpu_run_ctrl_dump_seq
  import cpu_run_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 32,
  parameter int unsigned REG_NUM   = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            active_i,
  input  logic            dump_ready_i,
  input  logic [31:0]     pc_latch_i,
  input  logic [31:0]     mem_rdata_i,
  input  logic [31:0]     reg_rdata_i,
  output logic [31:0]     dump_data_o,
  output dump_idx_t       dump_idx_o,
  output logic            dump_last_o,
  output logic [4:0]      dbg_mem_addr_o,
  output logic [4:0]      dbg_reg_addr_o,
  output logic            last_fire_o
);

  localparam dump_idx_t  LastIdx   = dump_idx_t'(MEM_WORDS + REG_NUM);
  localparam dump_idx_t  RegBase   = dump_idx_t'(reg_idx_base(MEM_WORDS));
  localparam logic [4:0] MemBaseLo = 5'(MemIdxBase);
  localparam logic [4:0] RegBaseLo = 5'(reg_idx_base(MEM_WORDS));

  dump_idx_t idx;
  logic      at_last;

  assign at_last = (idx == LastIdx);

  // Index parks at the last word so the final handshake never overruns it.
  always_ff @(posedge clk_i) begin
    if (rst_i || !active_i) begin
      idx <= '0;
    end else if (dump_ready_i && !at_last) begin
      idx <= idx + dump_idx_t'(1);
    end
  end

  always_comb begin
    dump_data_o    = '0;
    dbg_mem_addr_o = '0;
    dbg_reg_addr_o = '0;
    if (active_i) begin
      dbg_mem_addr_o = idx[4:0] - MemBaseLo;
      dbg_reg_addr_o = idx[4:0] - RegBaseLo;
      if (idx == dump_idx_t'(PcIdx)) begin
        dump_data_o = pc_latch_i;
      end else if (idx < RegBase) begin
        dump_data_o = mem_rdata_i;
      end else begin
        dump_data_o = reg_rdata_i;
      end
    end
  end

  assign dump_idx_o  = idx;
  assign dump_last_o = active_i && at_last;
  assign last_fire_o = active_i && at_last && dump_ready_i;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt sequencer for the single-cycle CPU: run gating, halt/timeout detection, state dump.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = 32,
  parameter int unsigned REG_NUM    = 32,
  parameter int unsigned MAX_CYCLES = 200,
  parameter logic [31:0] HALT_WORD  = HaltWordDefault
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic        run_o,
  output logic        halted_o,
  output logic        timeout_o,
  output logic [15:0] cycle_cnt_o,
  output logic [4:0]  dbg_mem_addr_o,
  output logic [4:0]  dbg_reg_addr_o,
  input  logic [31:0] mem_rdata_i,
  input  logic [31:0] reg_rdata_i,
  output logic        dump_valid_o,
  input  logic        dump_ready_i,
  output logic [31:0] dump_data_o,
  output logic [6:0]  dump_idx_o,
  output logic        dump_last_o,
  output logic        done_o
);

  localparam logic [15:0] BudgetLast = 16'(MAX_CYCLES - 1);

  logic [1:0]  state;
  logic [15:0] cycle_cnt;
  logic        halted;
  logic        timeout;
  logic [31:0] pc_latch;
  logic        is_halt;
  logic        budget_hit;
  logic        last_fire;

  assign is_halt    = (instr_i == HALT_WORD);
  assign budget_hit = (cycle_cnt == BudgetLast);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= StIdle;
      cycle_cnt <= '0;
      halted    <= 1'b0;
      timeout   <= 1'b0;
      pc_latch  <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (start_i) begin
            state     <= StRun;
            cycle_cnt <= '0;
          end
        end
        StRun: begin
          // Halt takes precedence when it coincides with budget exhaustion.
          if (is_halt) begin
            pc_latch <= pc_i;
            halted   <= 1'b1;
            state    <= StDump;
          end else if (budget_hit) begin
            pc_latch <= pc_i;
            timeout  <= 1'b1;
            state    <= StDump;
          end else begin
            cycle_cnt <= cycle_cnt + 16'd1;
          end
        end
        StDump: begin
          if (last_fire) begin
            state <= StDone;
          end
        end
        default: state <= state;
      endcase
    end
  end

  assign run_o        = (state == StRun) && !is_halt && !budget_hit;
  assign dump_valid_o = (state == StDump);
  assign done_o       = (state == StDone);
  assign halted_o     = halted;
  assign timeout_o    = timeout;
  assign cycle_cnt_o  = cycle_cnt;

  cpu_run_ctrl_dump_seq #(
    .MEM_WORDS (MEM_WORDS),
    .REG_NUM   (REG_NUM)
  ) u_dump_seq (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .active_i       (dump_valid_o),
    .dump_ready_i   (dump_ready_i),
    .pc_latch_i     (pc_latch),
    .mem_rdata_i    (mem_rdata_i),
    .reg_rdata_i    (reg_rdata_i),
    .dump_data_o    (dump_data_o),
    .dump_idx_o     (dump_idx_o),
    .dump_last_o    (dump_last_o),
    .dbg_mem_addr_o (dbg_mem_addr_o),
    .dbg_reg_addr_o (dbg_reg_addr_o),
    .last_fire_o    (last_fire)
  );

endmodule
